matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter: DATA_W, 8, signed operand width; ACC_W = 2*DATA_W+1 is derived and not overridable.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: a11,a12,a21,a22  input  DATA_W each  signed matrix A elements.
REQ-005 SHALL have ports: b11,b12,b21,b22  input  DATA_W each  signed matrix B elements.
REQ-006 SHALL have port: start  input  1  job request; sampled only when ready=1.
REQ-007 SHALL have port: abort  input  1  cancels the job in progress.
REQ-008 SHALL have port: ready  output  1  high only in IDLE.
REQ-009 SHALL have port: busy  output  1  high only in MUL.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports: c11,c12,c21,c22  output  ACC_W each  signed registered results of C = A x B.
REQ-012 SHALL have port: sat  output  1  saturation flag (see Configuration).

Function
REQ-013 SHALL time-share one signed DATA_W x DATA_W multiplier across all 8 products, one product per cycle.
REQ-014 SHALL implement FSM states IDLE, MUL, DONE: IDLE->MUL on start; MUL->DONE after the 8th product; DONE->IDLE unconditionally; MUL->IDLE on abort.
REQ-015 SHALL capture all 8 operands on the edge that accepts start; input changes after acceptance do not affect the job.
REQ-016 SHALL use a 3-bit step counter k, cleared on accept, in fixed order: k0 a11*b11, k1 a12*b21, k2 a11*b12, k3 a12*b22, k4 a21*b11, k5 a22*b21, k6 a21*b12, k7 a22*b22.
REQ-017 SHALL sign-extend each product to ACC_W; even k loads the accumulator, odd k adds to it and writes the sum to c11/c12/c21/c22 shadow registers in that order.
REQ-018 SHALL update c11..c22 together on the MUL->DONE edge only; outputs hold their values at all other times.
REQ-019 SHALL assert done for exactly one cycle, beginning 8 edges after the accepting edge (ready returns high the following cycle).
REQ-020 SHALL ignore start while busy or in DONE; no queuing.
REQ-021 SHALL, on abort in MUL, return to IDLE on the next edge with no done and c11..c22 unchanged; abort in IDLE/DONE is ignored.
REQ-022 SHALL give abort priority over completion when abort is asserted in the k7 cycle.

Reset
REQ-023 SHALL, when rst=1 at an edge, force state IDLE, k=0, c11..c22=0, done=0, busy=0, sat=0, ready=1, including mid-job; rst overrides start and abort.

Configuration
REQ-024 SHALL honour macro MATMUL_SEQ_SAT_EN: when defined, each result is clamped to the signed 16-bit range [-32768, 32767] at writeback and sat is set high for that job if any element clamped (held until the next completion or reset).
REQ-025 SHALL, without MATMUL_SEQ_SAT_EN, output full ACC_W results and tie sat to 0.

Structure
REQ-026 SHALL place the FSM state encoding, DATA_W/ACC_W defaults, and the 16-bit saturation limits in shared package matmul_pkg.
REQ-027 SHALL instantiate the multiplier as one sub-module, mac_pe (signed product, combinational, DATA_W in, 2*DATA_W out).

Verification
REQ-028 SHALL cover: A=[1,2;3,4], B=identity, start -> done 8 edges later, C=[1,2;3,4].
REQ-029 SHALL cover: A=[-3,5;7,-2], B=[4,-1;6,8] -> C=[18,43;16,-23].
REQ-030 SHALL cover: all operands -128 -> C all 32768 (macro off); C all 32767 and sat=1 (macro on).
REQ-031 SHALL cover: second start pulsed at k=3 -> exactly one done, results from first operand set.
REQ-032 SHALL cover: abort at k=4 after a prior job C=[1,2;3,4] -> no done, C stays [1,2;3,4], ready=1 next cycle.
REQ-033 SHALL cover: rst at k=5 -> next cycle C=0, busy=0, done=0, ready=1; a fresh job then completes correctly.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix-multiply sequencer.
// State encoding, default widths and the 16-bit saturation limits.
package matmul_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 2 * DATA_W_DEF + 1;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_pe.sv
// Combinational signed multiplier shared by every product step.
// Full-precision product, no rounding or truncation.
module mac_pe #(
    parameter int DATA_W = 8
) (
    input  logic signed [DATA_W-1:0]   i_a,
    input  logic signed [DATA_W-1:0]   i_b,
    output logic signed [2*DATA_W-1:0] o_p
);

    assign o_p = i_a * i_b;

endmodule

// File: rtl/matmul_sequencer.sv
// 2x2 signed matrix multiply over one shared multiplier, 8 cycles/job.
// Define MATMUL_SEQ_SAT_EN to clamp results to 16 bits and drive sat.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    localparam int ACC_W  = 2 * DATA_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a11,
    input  logic signed [DATA_W-1:0] a12,
    input  logic signed [DATA_W-1:0] a21,
    input  logic signed [DATA_W-1:0] a22,
    input  logic signed [DATA_W-1:0] b11,
    input  logic signed [DATA_W-1:0] b12,
    input  logic signed [DATA_W-1:0] b21,
    input  logic signed [DATA_W-1:0] b22,
    input  logic                     start,
    input  logic                     abort,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  c11,
    output logic signed [ACC_W-1:0]  c12,
    output logic signed [ACC_W-1:0]  c21,
    output logic signed [ACC_W-1:0]  c22,
    output logic                     sat
);

    state_t r_state;
    state_t w_next;

    logic [2:0] r_k;

    logic signed [DATA_W-1:0] r_a11, r_a12, r_a21, r_a22;
    logic signed [DATA_W-1:0] r_b11, r_b12, r_b21, r_b22;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_s11, r_s12, r_s21;
    logic signed [ACC_W-1:0] r_c11, r_c12, r_c21, r_c22;

    logic signed [DATA_W-1:0]   w_opa;
    logic signed [DATA_W-1:0]   w_opb;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_ext;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_r11, w_r12, w_r21, w_r22;

    logic w_accept;
    logic w_finish;

    // k[2] picks the A row, k[0] the inner index, k[1] the B column
    always_comb begin
        w_opa = r_a11;
        w_opb = r_b11;
        unique case ({r_k[2], r_k[0]})
            2'b00:   w_opa = r_a11;
            2'b01:   w_opa = r_a12;
            2'b10:   w_opa = r_a21;
            default: w_opa = r_a22;
        endcase
        unique case ({r_k[0], r_k[1]})
            2'b00:   w_opb = r_b11;
            2'b01:   w_opb = r_b12;
            2'b10:   w_opb = r_b21;
            default: w_opb = r_b22;
        endcase
    end

    mac_pe #(
        .DATA_W(DATA_W)
    ) u_pe (
        .i_a(w_opa),
        .i_b(w_opb),
        .o_p(w_prod)
    );

    assign w_ext = {w_prod[2*DATA_W-1], w_prod};
    assign w_sum = r_acc + w_ext;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_finish = (r_state == S_MUL) && (r_k == 3'd7) && !abort;

`ifdef MATMUL_SEQ_SAT_EN
    localparam logic signed [ACC_W-1:0] L_MAX = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] L_MIN = ACC_W'(SAT_MIN);

    function automatic logic signed [ACC_W-1:0] f_clamp(
        input logic signed [ACC_W-1:0] v
    );
        if (v > L_MAX) return L_MAX;
        if (v < L_MIN) return L_MIN;
        return v;
    endfunction

    logic w_clip;
    logic r_sat;

    assign w_r11  = f_clamp(r_s11);
    assign w_r12  = f_clamp(r_s12);
    assign w_r21  = f_clamp(r_s21);
    assign w_r22  = f_clamp(w_sum);
    assign w_clip = (w_r11 != r_s11) || (w_r12 != r_s12) ||
                    (w_r21 != r_s21) || (w_r22 != w_sum);
    assign sat    = r_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_finish) begin
            r_sat <= w_clip;
        end
    end
`else
    assign w_r11 = r_s11;
    assign w_r12 = r_s12;
    assign w_r21 = r_s21;
    assign w_r22 = w_sum;
    assign sat   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_MUL;
            S_MUL: begin
                if (abort)              w_next = S_IDLE;
                else if (r_k == 3'd7)   w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= 3'd0;
            r_acc   <= '0;
            r_s11   <= '0;
            r_s12   <= '0;
            r_s21   <= '0;
            r_c11   <= '0;
            r_c12   <= '0;
            r_c21   <= '0;
            r_c22   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_k <= 3'd0;
            end else if (r_state == S_MUL) begin
                r_k <= r_k + 3'd1;
                if (!r_k[0]) begin
                    r_acc <= w_ext;
                end else begin
                    unique case (r_k[2:1])
                        2'd0:    r_s11 <= w_sum;
                        2'd1:    r_s12 <= w_sum;
                        2'd2:    r_s21 <= w_sum;
                        default: ;
                    endcase
                end
            end
            if (w_finish) begin
                r_c11 <= w_r11;
                r_c12 <= w_r12;
                r_c21 <= w_r21;
                r_c22 <= w_r22;
            end
        end
    end

    // Operand snapshot is only meaningful once a job is accepted
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a11 <= a11;
            r_a12 <= a12;
            r_a21 <= a21;
            r_a22 <= a22;
            r_b11 <= b11;
            r_b12 <= b12;
            r_b21 <= b21;
            r_b22 <= b22;
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state == S_MUL);
    assign done  = (r_state == S_DONE);
    assign c11   = r_c11;
    assign c12   = r_c12;
    assign c21   = r_c21;
    assign c22   = r_c22;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed scoreboard bench for matmul_sequencer.
// Honors MATMUL_SEQ_SAT_EN when computing expected results.
module tb_matmul_sequencer;

    localparam int DW = 8;
    localparam int AW = 2 * DW + 1;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic signed [DW-1:0] a11, a12, a21, a22;
    logic signed [DW-1:0] b11, b12, b21, b22;
    logic ready, busy, done, sat;
    logic signed [AW-1:0] c11, c12, c21, c22;

    matmul_sequencer #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22),
        .b11(b11), .b12(b12), .b21(b21), .b22(b22),
        .start(start), .abort(abort),
        .ready(ready), .busy(busy), .done(done),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c11;
        int c12;
        int c21;
        int c22;
        bit sat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int clampv(input int v, inout bit s);
`ifdef MATMUL_SEQ_SAT_EN
        if (v > 32767) begin s = 1'b1; return 32767; end
        if (v < -32768) begin s = 1'b1; return -32768; end
`endif
        return v;
    endfunction

    task automatic set_ops(input int x11, x12, x21, x22,
                           input int y11, y12, y21, y22);
        a11 = DW'(x11); a12 = DW'(x12); a21 = DW'(x21); a22 = DW'(x22);
        b11 = DW'(y11); b12 = DW'(y12); b21 = DW'(y21); b22 = DW'(y22);
    endtask

    task automatic push_exp;
        exp_t e;
        bit s;
        int p11, p12, p21, p22;
        s = 1'b0;
        p11 = int'(a11) * int'(b11) + int'(a12) * int'(b21);
        p12 = int'(a11) * int'(b12) + int'(a12) * int'(b22);
        p21 = int'(a21) * int'(b11) + int'(a22) * int'(b21);
        p22 = int'(a21) * int'(b12) + int'(a22) * int'(b22);
        e.c11 = clampv(p11, s);
        e.c12 = clampv(p12, s);
        e.c21 = clampv(p21, s);
        e.c22 = clampv(p22, s);
        e.sat = s;
        sb.push_back(e);
    endtask

    task automatic scramble;
        set_ops($urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic launch(input bit expect_done);
        if (expect_done) push_exp();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_c(input string tag, input int e11, e12, e21, e22);
        chk({tag, "_c11"}, c11, e11);
        chk({tag, "_c12"}, c12, e12);
        chk({tag, "_c21"}, c21, e21);
        chk({tag, "_c22"}, c22, e22);
    endtask

    // Runs from the first MUL cycle to done, then pops and compares
    task automatic wait_done(input string tag, input int pulse_at);
        int n;
        bit got;
        exp_t e;
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            if (n == 0) scramble();
            if (n == pulse_at) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
            if (done) got = 1'b1;
        end
        chk({tag, "_latency"}, n, 8);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            if (got) begin
                chk_c(tag, e.c11, e.c12, e.c21, e.c22);
                chk({tag, "_sat"}, int'(sat), int'(e.sat));
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_done_1cyc"}, int'(done), 0);
        chk({tag, "_ready_after"}, int'(ready), 1);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int d;
        d = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) d++;
        end
        chk({tag, "_extra_done"}, d, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sat", int'(sat), 0);
        chk_c("rst", 0, 0, 0, 0);

        set_ops(1, 2, 3, 4, 1, 0, 0, 1);
        launch(1'b1);
        chk("t1_busy", int'(busy), 1);
        wait_done("t1", -1);

        set_ops(-3, 5, 7, -2, 4, -1, 6, 8);
        launch(1'b1);
        wait_done("t2", -1);
        chk_c("t2_lit", 18, 43, 16, -23);

        set_ops(-128, -128, -128, -128, -128, -128, -128, -128);
        launch(1'b1);
        wait_done("t3", -1);
`ifdef MATMUL_SEQ_SAT_EN
        chk_c("t3_lit", 32767, 32767, 32767, 32767);
        chk("t3_lit_sat", int'(sat), 1);
`else
        chk_c("t3_lit", 32768, 32768, 32768, 32768);
        chk("t3_lit_sat", int'(sat), 0);
`endif

        set_ops(-3, 5, 7, -2, 4, -1, 6, 8);
        launch(1'b1);
        wait_done("t4", 3);
        count_dones("t4", 12);

        set_ops(1, 2, 3, 4, 1, 0, 0, 1);
        abort = 1'b1;
        launch(1'b1);
        abort = 1'b0;
        wait_done("t5pre", -1);
        set_ops(9, 9, 9, 9, 9, 9, 9, 9);
        launch(1'b0);
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_ready", int'(ready), 1);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk_c("t5", 1, 2, 3, 4);
        count_dones("t5", 12);

        set_ops(7, 7, 7, 7, 7, 7, 7, 7);
        launch(1'b0);
        for (int i = 0; i < 7; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_done", int'(done), 0);
        chk("t6_ready", int'(ready), 1);
        chk_c("t6", 1, 2, 3, 4);
        count_dones("t6", 10);

        set_ops(5, 6, 7, 8, 1, 2, 3, 4);
        launch(1'b0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_ready", int'(ready), 1);
        chk("t7_busy", int'(busy), 0);
        chk("t7_done", int'(done), 0);
        chk("t7_sat", int'(sat), 0);
        chk_c("t7", 0, 0, 0, 0);
        set_ops(5, -6, 7, 8, 1, 2, -3, 4);
        launch(1'b1);
        wait_done("t7b", -1);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
